int_ret_controller: RTL and testbench

//  Sequences interrupt entry and return for the program counter. Edge-detects the

---
 rtl/int_ret_controller.sv | 154 +++++++++++++++
 tb/tb_int_ret_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_ret_controller.sv
// int_ret_controller: interrupt entry / return sequencer for the program counter.
// A rising edge on int_req is latched as pending; the interrupt is entered on the
// next instruction boundary by strobing the PC with the ISR vector and pushing the
// return address onto a small LIFO. A return instruction pops the LIFO and hands
// the address back to the PC. All outputs are registered.
module int_ret_controller #(
  parameter int                        ADDR_WIDTH_MEM = 16,
  parameter int                        DDR_ADDR_WIDTH = 28,
  parameter int                        STACK_DEPTH    = 4,
  parameter int                        LEVEL_WIDTH    = 3,
  parameter logic [DDR_ADDR_WIDTH-1:0] ISR_BASE_ADDR  = 28'h400
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      int_req,
  input  logic                      int_mask,
  input  logic                      ins_boundary,
  input  logic                      ret_req,
  input  logic [ADDR_WIDTH_MEM-1:0] addr_cur_ins,
  output logic                      int_pc,
  output logic [DDR_ADDR_WIDTH-1:0] jmp_addr_pc,
  output logic                      ret_valid,
  output logic [ADDR_WIDTH_MEM-1:0] ret_addr_pc,
  output logic                      int_ack,
  output logic [LEVEL_WIDTH-1:0]    nest_level,
  output logic [1:0]                err_sticky
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_ENTER = 2'd2,
    ST_RETN  = 2'd3
  } state_t;

  state_t                    state_reg;
  state_t                    state_next;
  logic                      req_prev_reg;
  logic                      pend_reg;
  logic [LEVEL_WIDTH-1:0]    sp_reg;
  logic                      int_pc_reg;
  logic                      int_ack_reg;
  logic                      ret_valid_reg;
  logic [DDR_ADDR_WIDTH-1:0] jmp_addr_reg;
  logic [ADDR_WIDTH_MEM-1:0] ret_addr_reg;
  logic [1:0]                err_reg;

  logic [ADDR_WIDTH_MEM-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_WIDTH_MEM-1:0] top_data;

  logic req_edge;
  logic pend_now;
  logic stack_empty;
  logic stack_full;
  logic push;
  logic pop;
  logic err_empty;
  logic err_full;

  assign req_edge    = int_req & ~req_prev_reg;
  // An edge arriving this very cycle counts as pending for state decisions.
  assign pend_now    = pend_reg | req_edge;
  assign stack_empty = (sp_reg == '0);
  assign stack_full  = (sp_reg >= LEVEL_WIDTH'(STACK_DEPTH));

  // Next-state decode; push/pop fire on the transition into ENTER/RETN so that
  // the strobe, the stack update and nest_level all appear in the same cycle.
  always_comb begin
    state_next = state_reg;
    err_empty  = 1'b0;
    err_full   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ret_req && !stack_empty) begin
          state_next = ST_RETN;
        end else begin
          err_empty = ret_req;
          if (pend_now) state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        // A return outranks an entry on the same cycle; the pending flag survives.
        if (ret_req && !stack_empty) begin
          state_next = ST_RETN;
        end else begin
          err_empty = ret_req;
          if (ins_boundary && !int_mask) begin
            if (!stack_full) state_next = ST_ENTER;
            else             err_full   = 1'b1;
          end
        end
      end
      ST_ENTER: state_next = ST_IDLE;
      ST_RETN:  state_next = pend_now ? ST_PEND : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign push = (state_next == ST_ENTER);
  assign pop  = (state_next == ST_RETN);

  // Top-of-stack read mux (entry sp-1).
  always_comb begin
    top_data = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if ((sp_reg - LEVEL_WIDTH'(1)) == LEVEL_WIDTH'(i)) top_data = stack_mem[i];
    end
  end

  // Return-address storage; contents need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && sp_reg == LEVEL_WIDTH'(i)) stack_mem[i] <= addr_cur_ins;
    end
  end

  // Control state, pending flag, stack pointer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      req_prev_reg  <= 1'b0;
      pend_reg      <= 1'b0;
      sp_reg        <= '0;
      int_pc_reg    <= 1'b0;
      int_ack_reg   <= 1'b0;
      ret_valid_reg <= 1'b0;
      jmp_addr_reg  <= '0;
      ret_addr_reg  <= '0;
      err_reg       <= 2'b00;
    end else begin
      state_reg     <= state_next;
      req_prev_reg  <= int_req;
      if (push)          pend_reg <= 1'b0;
      else if (req_edge) pend_reg <= 1'b1;
      if (push)     sp_reg <= sp_reg + LEVEL_WIDTH'(1);
      else if (pop) sp_reg <= sp_reg - LEVEL_WIDTH'(1);
      int_pc_reg    <= push;
      int_ack_reg   <= push;
      ret_valid_reg <= pop;
      if (push) jmp_addr_reg <= ISR_BASE_ADDR;
      if (pop)  ret_addr_reg <= top_data;
      err_reg       <= err_reg | {err_full, err_empty};
    end
  end

  assign int_pc      = int_pc_reg;
  assign int_ack     = int_ack_reg;
  assign jmp_addr_pc = jmp_addr_reg;
  assign ret_valid   = ret_valid_reg;
  assign ret_addr_pc = ret_addr_reg;
  assign nest_level  = sp_reg;
  assign err_sticky  = err_reg;

endmodule

// File: tb/tb_int_ret_controller.sv
// Directed bench for int_ret_controller: entry, return, nesting to full,
// empty-stack return, masking, return/entry priority and reset during entry.
module tb_int_ret_controller;

  logic        clk;
  logic        rst;
  logic        int_req;
  logic        int_mask;
  logic        ins_boundary;
  logic        ret_req;
  logic [15:0] addr_cur_ins;
  logic        int_pc;
  logic [27:0] jmp_addr_pc;
  logic        ret_valid;
  logic [15:0] ret_addr_pc;
  logic        int_ack;
  logic [2:0]  nest_level;
  logic [1:0]  err_sticky;

  int checks = 0;
  int errors = 0;

  int_ret_controller dut (
    .clk          (clk),
    .rst          (rst),
    .int_req      (int_req),
    .int_mask     (int_mask),
    .ins_boundary (ins_boundary),
    .ret_req      (ret_req),
    .addr_cur_ins (addr_cur_ins),
    .int_pc       (int_pc),
    .jmp_addr_pc  (jmp_addr_pc),
    .ret_valid    (ret_valid),
    .ret_addr_pc  (ret_addr_pc),
    .int_ack      (int_ack),
    .nest_level   (nest_level),
    .err_sticky   (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raise a request, then retire an instruction at addr; expect entry at depth lvl.
  task automatic enter_one(input logic [15:0] addr, input logic [2:0] lvl);
    int_req = 1'b1;
    tick();
    int_req      = 1'b0;
    addr_cur_ins = addr;
    ins_boundary = 1'b1;
    tick();
    chk("nest_int_pc", 32'(int_pc), 32'd1);
    chk("nest_level", 32'(nest_level), 32'(lvl));
    ins_boundary = 1'b0;
    tick();
  endtask

  // Issue a return and expect the popped address and new depth.
  task automatic do_ret(input logic [15:0] addr, input logic [2:0] lvl);
    ret_req = 1'b1;
    tick();
    chk("ret_valid", 32'(ret_valid), 32'd1);
    chk("ret_addr", 32'(ret_addr_pc), 32'(addr));
    chk("ret_level", 32'(nest_level), 32'(lvl));
    ret_req = 1'b0;
    tick();
    chk("ret_pulse_end", 32'(ret_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; int_req = 1'b0; int_mask = 1'b0; ins_boundary = 1'b0;
    ret_req = 1'b0; addr_cur_ins = 16'h0000;
    tick();
    chk("rst_int_pc", 32'(int_pc), 32'd0);
    chk("rst_int_ack", 32'(int_ack), 32'd0);
    chk("rst_ret_valid", 32'(ret_valid), 32'd0);
    chk("rst_jmp", 32'(jmp_addr_pc), 32'd0);
    chk("rst_ret_addr", 32'(ret_addr_pc), 32'd0);
    chk("rst_nest", 32'(nest_level), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    rst = 1'b1;
    tick();

    // Test 1: request, boundary three cycles later, entry one cycle after boundary.
    int_req = 1'b1; addr_cur_ins = 16'h0012;
    tick();
    chk("t1_wait0", 32'(int_pc), 32'd0);
    int_req = 1'b0;
    tick();
    chk("t1_wait1", 32'(int_pc), 32'd0);
    tick();
    chk("t1_wait2", 32'(int_pc), 32'd0);
    ins_boundary = 1'b1;
    tick();
    chk("t1_int_pc", 32'(int_pc), 32'd1);
    chk("t1_int_ack", 32'(int_ack), 32'd1);
    chk("t1_jmp", 32'(jmp_addr_pc), 32'h400);
    chk("t1_nest", 32'(nest_level), 32'd1);
    ins_boundary = 1'b0;
    tick();
    chk("t1_pulse_end", 32'(int_pc), 32'd0);
    chk("t1_ack_end", 32'(int_ack), 32'd0);
    chk("t1_jmp_hold", 32'(jmp_addr_pc), 32'h400);

    // Test 2: return pops 0x0012.
    do_ret(16'h0012, 3'd0);

    // Test 3: fill the stack, blocked fifth request, return, then fifth enters.
    enter_one(16'h0010, 3'd1);
    enter_one(16'h0020, 3'd2);
    enter_one(16'h0030, 3'd3);
    enter_one(16'h0040, 3'd4);
    int_req = 1'b1;
    tick();
    int_req = 1'b0; addr_cur_ins = 16'h0050; ins_boundary = 1'b1;
    tick();
    chk("t3_blocked", 32'(int_pc), 32'd0);
    chk("t3_err_full", 32'(err_sticky), 32'd2);
    chk("t3_nest_full", 32'(nest_level), 32'd4);
    ins_boundary = 1'b0;
    do_ret(16'h0040, 3'd3);
    chk("t3_still_wait", 32'(int_pc), 32'd0);
    ins_boundary = 1'b1;
    tick();
    chk("t3_fifth_int_pc", 32'(int_pc), 32'd1);
    chk("t3_fifth_nest", 32'(nest_level), 32'd4);
    ins_boundary = 1'b0;
    tick();
    do_ret(16'h0050, 3'd3);
    do_ret(16'h0030, 3'd2);
    do_ret(16'h0020, 3'd1);
    do_ret(16'h0010, 3'd0);

    // Test 4: return with empty stack after a fresh reset.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    ret_req = 1'b1;
    tick();
    chk("t4_no_ret", 32'(ret_valid), 32'd0);
    chk("t4_err_empty", 32'(err_sticky), 32'd1);
    ret_req = 1'b0;
    tick();
    chk("t4_no_ret_late", 32'(ret_valid), 32'd0);
    chk("t4_ret_addr", 32'(ret_addr_pc), 32'd0);

    // Test 5: masked boundaries defer entry; unmasked boundary enters.
    int_mask = 1'b1; int_req = 1'b1;
    tick();
    int_req = 1'b0; addr_cur_ins = 16'h0077; ins_boundary = 1'b1;
    tick();
    chk("t5_masked0", 32'(int_pc), 32'd0);
    tick();
    chk("t5_masked1", 32'(int_pc), 32'd0);
    int_mask = 1'b0;
    tick();
    chk("t5_unmask_int_pc", 32'(int_pc), 32'd1);
    chk("t5_unmask_nest", 32'(nest_level), 32'd1);
    ins_boundary = 1'b0;
    tick();
    // Return and boundary on the same cycle: return wins, entry follows.
    int_req = 1'b1;
    tick();
    int_req = 1'b0; ret_req = 1'b1; ins_boundary = 1'b1; addr_cur_ins = 16'h0088;
    tick();
    chk("t5_prio_ret", 32'(ret_valid), 32'd1);
    chk("t5_prio_no_int", 32'(int_pc), 32'd0);
    chk("t5_prio_addr", 32'(ret_addr_pc), 32'h0077);
    chk("t5_prio_nest", 32'(nest_level), 32'd0);
    ret_req = 1'b0; ins_boundary = 1'b0;
    tick();
    chk("t5_tail_wait", 32'(int_pc), 32'd0);
    ins_boundary = 1'b1;
    tick();
    chk("t5_tail_int_pc", 32'(int_pc), 32'd1);
    chk("t5_tail_nest", 32'(nest_level), 32'd1);
    ins_boundary = 1'b0;
    tick();

    // Test 6: reset asserted during the ENTER cycle.
    int_req = 1'b1;
    tick();
    int_req = 1'b0; ins_boundary = 1'b1; addr_cur_ins = 16'h0099;
    tick();
    chk("t6_in_enter", 32'(int_pc), 32'd1);
    chk("t6_nest_pre", 32'(nest_level), 32'd2);
    ins_boundary = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_async_int_pc", 32'(int_pc), 32'd0);
    chk("t6_async_ack", 32'(int_ack), 32'd0);
    chk("t6_async_nest", 32'(nest_level), 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_strobe", 32'(int_pc), 32'd0);
    end
    chk("t6_err_clear", 32'(err_sticky), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
